// File: rtl/demux14e2_buf_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
// Shared defaults and sizing helpers for the buffered 1-to-4 demultiplexer.
//   DATA_LEN_DEF : width of one data word
//   SEL_LEN_DEF  : lane-select width; lane count is 2**SEL_LEN
//   DEPTH_DEF    : entries per lane FIFO
//   CNT_LEN_DEF  : width of each per-lane delivery counter
// The helper functions derive the lane count and the pointer and occupancy
// widths, so every file sizes its vectors the same way.
// ---------------------------------------------------------------------------
package demux_pkg;

  localparam int DATA_LEN_DEF = 2;
  localparam int SEL_LEN_DEF  = 2;
  localparam int DEPTH_DEF    = 2;
  localparam int CNT_LEN_DEF  = 8;

  // Number of output lanes addressed by a select of the given width.
  function automatic int nr_out_of(input int sel_len);
    return 1 << sel_len;
  endfunction

  // Read/write pointer width. A single-entry FIFO still needs a one-bit
  // pointer so that the vector is legal; that bit simply stays at 0.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy must be able to hold 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int NR_OUT_DEF = nr_out_of(SEL_LEN_DEF);

endpackage

// File: rtl/demux14e2_buf_lane_fifo.sv
// ---------------------------------------------------------------------------
// lane_fifo
// One output lane of the demultiplexer: a small first-word-fall-through
// FIFO with a wrapping delivery counter.
//   clk, rst        : clock and synchronous active-high reset
//   push_valid      : write push_data at the tail (ignored when full)
//   push_data       : word to write
//   pop_ready       : sink accepts the head word (ignored when empty)
//   out_valid       : FIFO holds at least one word
//   out_data        : head word, forced to 0 while empty
//   full            : FIFO holds DEPTH words
//   cnt             : number of words delivered, wrapping at 2**CNT_LEN
// ---------------------------------------------------------------------------
module lane_fifo
  import demux_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int CNT_LEN  = CNT_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_valid,
  input  logic [DATA_LEN-1:0] push_data,
  input  logic                pop_ready,
  output logic                out_valid,
  output logic [DATA_LEN-1:0] out_data,
  output logic                full,
  output logic [CNT_LEN-1:0]  cnt
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int OCC_W = occ_width(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [DATA_LEN-1:0] mem_q [DEPTH];
  logic [DATA_LEN-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic [CNT_LEN-1:0]  cnt_q, cnt_d;

  logic empty;
  logic full_int;
  logic do_push;
  logic do_pop;

  // Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Full/empty come from the registered occupancy only, so a pop in this
  // cycle never frees a slot for a push in the same cycle (no pass-through).
  always_comb begin
    empty    = (occ_q == '0);
    full_int = (occ_q == OCC_FULL);
    do_push  = push_valid && !full_int;
    do_pop   = pop_ready && !empty;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end

    if (do_pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
      cnt_d    = cnt_q + 1'b1;  // wraps naturally, no saturation
    end

    // Simultaneous push and pop leaves the occupancy where it was.
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset: stale contents are never visible because the
  // head is masked to 0 whenever the occupancy is zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    out_valid = !empty;
    out_data  = empty ? '0 : mem_q[rd_ptr_q];
    full      = full_int;
    cnt       = cnt_q;
  end

endmodule

// File: rtl/demux14e2_buf.sv
// ---------------------------------------------------------------------------
// demux14e2_buf
// Buffered 1-to-NR_OUT demultiplexer. One valid/ready input stream carries a
// word plus a lane select; each word is queued in that lane's FIFO and each
// lane drains through its own valid/ready port.
//   clk, rst   : clock and synchronous active-high reset
//   in_valid   : input word present
//   in_ready   : selected lane can take a word (combinational from in_sel)
//   in_data    : input word
//   in_sel     : destination lane
//   out_valid  : per-lane head-valid flags
//   out_ready  : per-lane sink-ready flags
//   out_data   : lane n head at [DATA_LEN*(n+1)-1 : DATA_LEN*n]
//   lane_full  : per-lane full flags
//   lane_cnt   : lane n delivery count at [CNT_LEN*(n+1)-1 : CNT_LEN*n]
// ---------------------------------------------------------------------------
module demux14e2_buf
  import demux_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int SEL_LEN  = SEL_LEN_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int CNT_LEN  = CNT_LEN_DEF,
  localparam int NR_OUT  = nr_out_of(SEL_LEN)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_LEN-1:0]        in_data,
  input  logic [SEL_LEN-1:0]         in_sel,
  output logic [NR_OUT-1:0]          out_valid,
  input  logic [NR_OUT-1:0]          out_ready,
  output logic [NR_OUT*DATA_LEN-1:0] out_data,
  output logic [NR_OUT-1:0]          lane_full,
  output logic [NR_OUT*CNT_LEN-1:0]  lane_cnt
);

  logic [NR_OUT-1:0] lane_push;

  // Ready depends only on in_sel and registered lane state; out_ready has
  // no route to in_ready.
  always_comb begin
    in_ready          = !lane_full[in_sel];
    lane_push         = '0;
    lane_push[in_sel] = in_valid && in_ready;
  end

  for (genvar gi = 0; gi < NR_OUT; gi++) begin : g_lane
    lane_fifo #(
      .DATA_LEN (DATA_LEN),
      .DEPTH    (DEPTH),
      .CNT_LEN  (CNT_LEN)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .push_valid (lane_push[gi]),
      .push_data  (in_data),
      .pop_ready  (out_ready[gi]),
      .out_valid  (out_valid[gi]),
      .out_data   (out_data[DATA_LEN*gi +: DATA_LEN]),
      .full       (lane_full[gi]),
      .cnt        (lane_cnt[CNT_LEN*gi +: CNT_LEN])
    );
  end

endmodule

// File: tb/tb_demux14e2_buf.sv
module tb_demux14e2_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_data = 2'd0;
  logic [1:0]  in_sel = 2'd0;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = 4'd0;
  logic [7:0]  out_data;
  logic [3:0]  lane_full;
  logic [31:0] lane_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model: one queue per lane plus a delivery count per lane.
  logic [1:0] mq [4][$];
  int         mcnt [4];
  bit         model_on = 1'b0;

  always #5 clk = ~clk;

  demux14e2_buf dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .lane_full (lane_full),
    .lane_cnt  (lane_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Model update at the active edge, using the pre-edge lane contents.
  always @(posedge clk) begin : model
    bit acc;
    if (rst) begin
      for (int n = 0; n < 4; n++) begin
        mq[n].delete();
        mcnt[n] = 0;
      end
      model_on = 1'b1;
    end else begin
      acc = in_valid && (mq[in_sel].size() < 2);
      for (int n = 0; n < 4; n++) begin
        if (out_ready[n] && mq[n].size() > 0) begin
          $display("pop  lane=%0d data=%0d", n, mq[n][0]);
          void'(mq[n].pop_front());
          mcnt[n] = (mcnt[n] + 1) % 256;
        end
      end
      if (acc) begin
        mq[in_sel].push_back(in_data);
        $display("push lane=%0d data=%0d", in_sel, in_data);
      end
    end
  end

  // Cycle-by-cycle comparison on the falling edge.
  always @(negedge clk) begin : cmp
    logic [3:0]  ev;
    logic [3:0]  ef;
    logic [7:0]  ed;
    logic [31:0] ec;
    if (model_on) begin
      for (int n = 0; n < 4; n++) begin
        ev[n]         = mq[n].size() > 0;
        ef[n]         = mq[n].size() == 2;
        ed[2*n +: 2]  = (mq[n].size() > 0) ? mq[n][0] : 2'd0;
        ec[8*n +: 8]  = 8'(mcnt[n]);
      end
      chk("cyc_out_valid", 32'(out_valid), 32'(ev));
      chk("cyc_out_data",  32'(out_data),  32'(ed));
      chk("cyc_lane_full", 32'(lane_full), 32'(ef));
      chk("cyc_lane_cnt",  lane_cnt,       ec);
      chk("cyc_in_ready",  32'(in_ready),  32'(!ef[in_sel]));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_word(input logic [1:0] sel, input logic [1:0] data);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data",  32'(out_data),  32'h0);
    chk("rst_lane_full", 32'(lane_full), 32'h0);
    chk("rst_lane_cnt",  lane_cnt,       32'h0);
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'h1);
    end

    // Route one word to lane 2, then drain it
    push_word(2'd2, 2'b11);
    chk("route_valid", 32'(out_valid), 32'h4);
    chk("route_data",  32'(out_data[5:4]), 32'h3);
    out_ready = 4'b0100;
    step();
    out_ready = 4'b0000;
    chk("route_drain_valid", 32'(out_valid), 32'h0);
    chk("route_cnt2", 32'(lane_cnt[23:16]), 32'h1);

    // Fill lane 1, reject a third word, drain in order
    push_word(2'd1, 2'b01);
    push_word(2'd1, 2'b10);
    chk("fill_full", 32'(lane_full), 32'h2);
    in_sel = 2'd1;
    #1;
    chk("fill_rdy_sel1", 32'(in_ready), 32'h0);
    in_sel = 2'd0;
    #1;
    chk("fill_rdy_sel0", 32'(in_ready), 32'h1);
    push_word(2'd1, 2'b11);
    chk("fill_still_full", 32'(lane_full), 32'h2);
    chk("fill_head0", 32'(out_data[3:2]), 32'h1);
    out_ready = 4'b0010;
    step();
    chk("fill_head1", 32'(out_data[3:2]), 32'h2);
    step();
    out_ready = 4'b0000;
    chk("fill_empty", 32'(out_valid[1]), 32'h0);
    chk("fill_cnt1", 32'(lane_cnt[15:8]), 32'h2);

    // Full lane 3: pop and push requested together, push waits one cycle
    push_word(2'd3, 2'b01);
    push_word(2'd3, 2'b10);
    chk("full3_full", 32'(lane_full[3]), 32'h1);
    out_ready = 4'b1000;
    in_valid  = 1'b1;
    in_sel    = 2'd3;
    in_data   = 2'b11;
    #1;
    chk("full3_rdy", 32'(in_ready), 32'h0);
    step();
    chk("full3_occ1", 32'(lane_full[3]), 32'h0);
    chk("full3_head", 32'(out_data[7:6]), 32'h2);
    out_ready = 4'b0000;
    step();
    in_valid = 1'b0;
    chk("full3_occ2", 32'(lane_full[3]), 32'h1);
    out_ready = 4'b1000;
    step();
    chk("full3_head2", 32'(out_data[7:6]), 32'h3);
    step();
    out_ready = 4'b0000;
    chk("full3_empty", 32'(out_valid[3]), 32'h0);

    // Simultaneous drain of all lanes
    for (int n = 0; n < 4; n++) push_word(2'(n), 2'(n));
    chk("all_valid", 32'(out_valid), 32'hF);
    chk("all_data",  32'(out_data),  32'hE4);
    out_ready = 4'b1111;
    step();
    out_ready = 4'b0000;
    chk("all_drained", 32'(out_valid), 32'h0);
    chk("all_cnt", lane_cnt, 32'h04020301);

    // Counter wrap on lane 0: 255 more deliveries take it from 1 to 0
    out_ready = 4'b0001;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    for (int i = 0; i < 255; i++) begin
      in_data = 2'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    out_ready = 4'b0000;
    chk("wrap_cnt", lane_cnt, 32'h04020300);
    chk("wrap_empty", 32'(out_valid), 32'h0);

    // Reset mid-stream with a handshake in the reset cycle
    push_word(2'd0, 2'b01);
    push_word(2'd2, 2'b10);
    chk("pre_rst_valid", 32'(out_valid), 32'h5);
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_sel    = 2'd2;
    in_data   = 2'b11;
    out_ready = 4'b0001;
    step();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    chk("mrst_valid", 32'(out_valid), 32'h0);
    chk("mrst_data",  32'(out_data),  32'h0);
    chk("mrst_full",  32'(lane_full), 32'h0);
    chk("mrst_cnt",   lane_cnt,       32'h0);
    step();
    step();
    chk("mrst_quiet", 32'(out_valid), 32'h0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
